alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU with a start/done handshake. It extends the team's 8-bit combinational ALU to WIDTH bits and adds subtract, OR, a true bitwise complement, an iterative shift-add multiply and an iterative left shift. It sits between the register file and the accumulator write-back. The control FSM issues `start` and stalls on `busy` until `done`.

## Interface
- `WIDTH`, default 8: operand and result width; must be a power of two and at least 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  3  operation select; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while a multi-cycle operation is in progress.
- `done`  out  1  one-cycle pulse when `result`, `c` and `z` update.
- `result`  out  WIDTH  registered result; holds its value between operations.
- `c`  out  1  registered carry/borrow/overflow flag.
- `z`  out  1  registered zero flag; equals (`result`==0) of the same update.

## Operation
- Op encoding, with the result and `c` for each:
  - 000 ADD: result = a+b mod 2^WIDTH; c = carry out.
  - 001 SUB: result = a−b mod 2^WIDTH; c = borrow (a<b).
  - 010 PASS: result = b; c=0.
  - 011 AND: result = a&b; c=0.
  - 100 OR: result = a|b; c=0.
  - 101 NOT: result = ~a (bitwise); c=0.
  - 110 MUL: result = low WIDTH bits of a*b (unsigned); c = 1 if the high WIDTH bits are nonzero.
  - 111 SHL: shift a left by s = b[log2(WIDTH)-1:0]; c = the last bit shifted out, or 0 when s=0.
- FSM states:
  - IDLE: `start`=1 with op 000–101, or SHL with s≤1, completes in one cycle and stays in IDLE. `start`=1 with MUL, or SHL with s≥2, latches the operands into internal registers and moves to RUN.
  - RUN: `busy`=1. Counter loads WIDTH for MUL or s for SHL and decrements once per cycle.
    - MUL: each cycle examines one bit of b, LSB first, and adds the shifted a into a 2·WIDTH accumulator.
    - SHL: shifts one bit per cycle.
  - RUN → IDLE when the counter reaches 0. On that transition, `result`/`c`/`z` are written and `done` pulses.
- `start` while `busy`=1 is ignored. No queuing. The in-flight operation is unaffected.
- Inputs `a`, `b`, `op` may change freely after the accept edge. The operation uses the latched copies.
- `result`, `c`, `z` change only on a `done` cycle.
- Reset values: `result`=0, `c`=0, `z`=1, `busy`=0, `done`=0, FSM=IDLE, counter=0, accumulator=0.
- Reset asserted mid-RUN aborts the operation immediately, without a `done` pulse, and all outputs take their reset values.

## Timing
- Accept edge E: the rising edge where `start`=1 and `busy`=0.
- Single-cycle ops (including SHL with s≤1): `result`/`c`/`z` update and `done`=1 on edge E+1. No `busy`.
- MUL: `busy`=1 from edge E through edge E+WIDTH. Results and `done` arrive on edge E+WIDTH, the same edge on which `busy` falls.
- SHL with s≥2: same pattern as MUL with latency s.
- `done` is high for exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high (`busy`=0), giving back-to-back throughput of one op per cycle for single-cycle ops.
- Every output is a flop. No combinational path runs from inputs to outputs.

## Test plan
- Reset then ADD, WIDTH=8: a=200, b=100 → `result`=0x2C, `c`=1, `z`=0, `done` one cycle after accept. Immediately follow with SUB a=5, b=5 → `result`=0, `z`=1, `c`=0. Then SUB a=3, b=5 → `result`=0xFE, `c`=1.
- PASS/AND/OR/NOT on a=0xF0, b=0x3C → 0x3C, 0x30, 0xFC, 0x0F respectively, `c`=0 each. Issue back-to-back on consecutive cycles and check four consecutive `done` pulses.
- MUL a=15, b=17 → `result`=0xFF, `c`=0, `busy` high 8 cycles, `done` at E+8. MUL a=16, b=16 → `result`=0, `c`=1, `z`=1.
- SHL a=0x81, b=1 → `result`=0x02, `c`=1, latency 1. SHL a=0x81, b=3 → `result`=0x08, `c`=0, latency 3. SHL b=8 (s=0) → `result`=0x81, `c`=0, latency 1.
- Start MUL, pulse `start` with op=000 at E+3 → that ADD is ignored; `result`/`done` reflect only the MUL at E+8.
- Start MUL, assert `rst_n`=0 at E+4 → outputs return to reset values with no `done`. After release, ADD 1+1 → `result`=2.

Source files
------------

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/done handshake; MUL and long SHL run
// iteratively in a RUN state while busy is high, all other ops take one cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             z,
  output logic             dbg_state
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_PASS = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  // Handshake: a request is accepted on a rising edge where start=1 and
  // busy=0; done pulses for one cycle on the edge result/c/z are written.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;

  logic               accept;
  logic               multi_in;
  logic [SW-1:0]      s_in;

  logic               pend;
  logic [2:0]         p_op;
  logic [WIDTH-1:0]   p_a;
  logic [WIDTH-1:0]   p_b;

  logic               run_mul;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [WIDTH-1:0]   single_res;
  logic               single_c;
  logic [WIDTH:0]     wide;
  logic [SW-1:0]      p_s;

  assign busy      = (state == RUN);
  assign dbg_state = state;
  assign accept    = start && !busy;
  assign s_in      = b[SW-1:0];
  assign multi_in  = (op == OP_MUL) || ((op == 3'b111) && (s_in > SW'(1)));
  assign p_s       = p_b[SW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && multi_in) state_next = RUN;
      RUN:  if (cnt == CW'(1))      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration: MUL adds the shifted multiplicand when the current
  // multiplier bit is set; SHL moves the operand one place toward the MSB.
  always_comb begin
    acc_next = acc;
    if (run_mul) acc_next = acc + (mplier[0] ? mcand : '0);
    else         acc_next = acc << 1;
  end

  // Single-cycle ops evaluate the operands latched on the accept edge.
  always_comb begin
    single_res = '0;
    single_c   = 1'b0;
    wide       = '0;
    case (p_op)
      OP_ADD: begin
        wide       = {1'b0, p_a} + {1'b0, p_b};
        single_res = wide[WIDTH-1:0];
        single_c   = wide[WIDTH];
      end
      OP_SUB: begin
        wide       = {1'b0, p_a} - {1'b0, p_b};
        single_res = wide[WIDTH-1:0];
        single_c   = wide[WIDTH];
      end
      OP_PASS: single_res = p_b;
      OP_AND:  single_res = p_a & p_b;
      OP_OR:   single_res = p_a | p_b;
      OP_NOT:  single_res = ~p_a;
      default: begin
        // SHL with s of 0 or 1; larger shifts go through RUN
        if (p_s == '0) begin
          single_res = p_a;
        end else begin
          single_res = p_a << 1;
          single_c   = p_a[WIDTH-1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      result  <= '0;
      c       <= 1'b0;
      z       <= 1'b1;
      pend    <= 1'b0;
      p_op    <= '0;
      p_a     <= '0;
      p_b     <= '0;
      run_mul <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      done <= 1'b0;
      pend <= accept && !multi_in;
      if (pend) begin
        result <= single_res;
        c      <= single_c;
        z      <= (single_res == '0);
        done   <= 1'b1;
      end
      if (accept) begin
        p_op <= op;
        p_a  <= a;
        p_b  <= b;
      end
      if (accept && multi_in) begin
        run_mul <= (op == OP_MUL);
        cnt     <= (op == OP_MUL) ? CW'(WIDTH) : CW'(s_in);
        acc     <= (op == OP_MUL) ? '0 : {{WIDTH{1'b0}}, a};
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
      end else if (state == RUN) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result <= acc_next[WIDTH-1:0];
          c      <= run_mul ? (|acc_next[2*WIDTH-1:WIDTH]) : acc_next[WIDTH];
          z      <= (acc_next[WIDTH-1:0] == '0);
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed sequences plus random traffic, checked every
// cycle against an arithmetic reference model and a due-cycle scoreboard.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c;
  logic         z;
  logic         dbg_state;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c(c), .z(z),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: expected result/carry and the cycle on which done must pulse
  logic [W-1:0] exp_q[$];
  logic         expc_q[$];
  int           due_q[$];
  int           cyc = 0;
  int           busy_end = 0;
  logic         m_busy = 1'b0;
  logic [W-1:0] last_res = '0;
  logic         last_c = 1'b0;

  // reference model from the operation table, plain arithmetic
  task automatic ref_model(input logic [2:0] rop, input logic [W-1:0] ra,
                           input logic [W-1:0] rb, output logic [W-1:0] res,
                           output logic rc, output int lat);
    longint ua, ub, full, s;
    ua = longint'(ra);
    ub = longint'(rb);
    lat = 1;
    rc = 1'b0;
    full = 0;
    case (rop)
      3'd0: begin full = ua + ub; rc = (full >= (64'd1 << W)); end
      3'd1: begin full = ua - ub; rc = (ua < ub); end
      3'd2: full = ub;
      3'd3: full = ua & ub;
      3'd4: full = ua | ub;
      3'd5: full = ~ua;
      3'd6: begin full = ua * ub; rc = ((full >> W) != 0); lat = W; end
      default: begin
        s = ub % W;
        full = ua << s;
        rc = (s == 0) ? 1'b0 : 1'((ua >> (W - s)) & 1);
        lat = (s >= 2) ? int'(s) : 1;
      end
    endcase
    res = W'(full);
  endtask

  // one clock: model acceptance, then compare every output after the edge
  task automatic tick();
    logic [W-1:0] r;
    logic         rc;
    int           lat;
    int           e;
    if (start && !m_busy) begin
      ref_model(op, a, b, r, rc, lat);
      e = cyc + 1;
      exp_q.push_back(r);
      expc_q.push_back(rc);
      if (lat == 1) begin
        due_q.push_back(e + 1);
      end else begin
        busy_end = e + lat;
        due_q.push_back(e + lat);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    m_busy = (cyc < busy_end);
    check("busy", busy, m_busy);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      last_res = exp_q.pop_front();
      last_c   = expc_q.pop_front();
      check("done", done, 1'b1);
    end else begin
      check("done_idle", done, 1'b0);
    end
    check("result", result, last_res);
    check("c", c, last_c);
    check("z", z, last_res == '0);
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((due_q.size() > 0 || m_busy) && n < 64) begin
      tick();
      n++;
    end
    check("drain_timeout", due_q.size(), 0);
  endtask

  task automatic apply_reset();
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 0);
    check("rst_c", c, 1'b0);
    check("rst_z", z, 1'b1);
    exp_q.delete(); expc_q.delete(); due_q.delete();
    busy_end = 0; m_busy = 1'b0; last_res = '0; last_c = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("rst_hold_done", done, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    @(posedge clk);
    cyc++;
    #1;
    apply_reset();

    // ADD with carry, SUB to zero, SUB with borrow, back to back
    issue(3'd0, 8'd200, 8'd100);
    issue(3'd1, 8'd5, 8'd5);
    issue(3'd1, 8'd3, 8'd5);
    drain();
    check("sub_borrow_res", result, 8'hFE);
    check("sub_borrow_c", c, 1'b1);

    // logic ops on consecutive cycles
    issue(3'd2, 8'hF0, 8'h3C);
    issue(3'd3, 8'hF0, 8'h3C);
    issue(3'd4, 8'hF0, 8'h3C);
    issue(3'd5, 8'hF0, 8'h3C);
    drain();
    check("not_res", result, 8'h0F);

    // multiply
    issue(3'd6, 8'd15, 8'd17);
    drain();
    check("mul_res", result, 8'hFF);
    check("mul_c", c, 1'b0);
    issue(3'd6, 8'd16, 8'd16);
    drain();
    check("mul_ovf_z", z, 1'b1);
    check("mul_ovf_c", c, 1'b1);

    // shifts: s=1, s=3, s=0
    issue(3'd7, 8'h81, 8'd1);
    drain();
    check("shl1_res", result, 8'h02);
    issue(3'd7, 8'h81, 8'd3);
    drain();
    check("shl3_res", result, 8'h08);
    issue(3'd7, 8'h81, 8'd8);
    drain();
    check("shl0_res", result, 8'h81);

    // start during MUL is ignored
    issue(3'd6, 8'd7, 8'd9);
    tick();
    issue(3'd0, 8'd1, 8'd1);
    drain();
    check("mul_ignore_add", result, 8'd63);

    // reset mid-run aborts without done
    issue(3'd6, 8'd7, 8'd9);
    repeat (3) tick();
    apply_reset();
    issue(3'd0, 8'd1, 8'd1);
    drain();
    check("post_rst_add", result, 8'd2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      end else begin
        tick();
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
